// File: rtl/mips_pkg.sv
// +------------------------------------------------------------------+
// | mips_pkg                                                          |
// | Shared opcode constants and fetch-stage state encoding.           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

   // Primary opcode field values (instr[31:26])
   localparam logic [5:0] R_FORMAT = 6'd0;
   localparam logic [5:0] J        = 6'd2;
   localparam logic [5:0] BEQ      = 6'd4;
   localparam logic [5:0] BNE      = 6'd5;
   localparam logic [5:0] ADDI     = 6'd8;
   localparam logic [5:0] ANDI     = 6'd12;
   localparam logic [5:0] ORI      = 6'd13;
   localparam logic [5:0] LW       = 6'd35;
   localparam logic [5:0] SW       = 6'd43;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// +------------------------------------------------------------------+
// | pc_next                                                           |
// | Combinational next-PC selection: sequential, conditional branch   |
// | (beq/bne) and, when FETCH_JUMP_EN is defined, the J-type jump.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        branch_ne,
   input  logic        zero,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;
   logic        w_taken;

   assign w_pc_plus4  = pc + 32'd4;
   // Word offset sign-extended then scaled to bytes
   assign w_br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign w_br_target = w_pc_plus4 + w_br_offset;
   assign w_taken     = (branch & zero) | (branch_ne & ~zero);
   assign pc_plus4    = w_pc_plus4;

`ifdef FETCH_JUMP_EN
   // Jump overrides any branch evaluation; otherwise branch or fall-through
   always_comb begin
      next_pc = w_pc_plus4;
      if (instr[31:26] == J) begin
         next_pc = {w_pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (w_taken) begin
         next_pc = w_br_target;
      end
   end
`else
   // Upper instruction bits only matter to the jump path
   logic w_unused_instr;
   assign w_unused_instr = &{1'b0, instr[31:16]};

   // Branch target when taken, else fall-through
   always_comb begin
      next_pc = w_pc_plus4;
      if (w_taken) begin
         next_pc = w_br_target;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +------------------------------------------------------------------+
// | fetch_unit                                                        |
// | Instruction fetch / sequencing: req/ack fetch from imem, holds    |
// | IR until retire, then loads the next PC from pc_next.             |
// | Optional macro: FETCH_JUMP_EN (J-type jump support in pc_next).   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        retire,
   input  logic        branch,
   input  logic        branch_ne,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   localparam logic [31:0] c_RESET_PC = RESET_PC & 32'hFFFF_FFFC;

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic         r_valid;
   logic         r_req;
   logic [31:0]  w_next_pc;
   logic [31:0]  w_pc_plus4;

   pc_next u_pc_next (
      .pc        (r_pc),
      .instr     (r_instr),
      .branch    (branch),
      .branch_ne (branch_ne),
      .zero      (zero),
      .pc_plus4  (w_pc_plus4),
      .next_pc   (w_next_pc)
   );

   // Fetch sequencer: request, capture IR on ack, hold until retire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= c_RESET_PC;
         r_instr <= 32'd0;
         r_valid <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
            end
            S_REQ: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_valid <= 1'b1;
                  r_req   <= 1'b0;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (retire) begin
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +------------------------------------------------------------------+
// | tb_fetch_unit                                                     |
// | Table-driven fetch/retire sequence with a next-address queue,     |
// | plus hand-written reset and spurious-handshake sequences.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] c_RESET_PC = 32'h0000_0040;
   localparam int          c_NVEC     = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        retire;
   logic        branch;
   logic        branch_ne;
   logic        zero;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   fetch_unit #(.RESET_PC(c_RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .retire      (retire),
      .branch      (branch),
      .branch_ne   (branch_ne),
      .zero        (zero),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      int          ack_dly;
      int          ret_dly;
      logic        br;
      logic        bne;
      logic        z;
      logic        spur;
      logic [31:0] next;
   } vec_t;

   vec_t        vt [c_NVEC];
   logic [31:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] p, input logic [31:0] d, input int ad,
                               input int rd, input logic b, input logic bn, input logic z,
                               input logic s, input logic [31:0] nx);
      vec_t v;
      v.pc = p; v.rdata = d; v.ack_dly = ad; v.ret_dly = rd;
      v.br = b; v.bne = bn; v.z = z; v.spur = s; v.next = nx;
      return v;
   endfunction

   // Wait for a request, pop the expected fetch address and compare
   task automatic check_fetch(input string name);
      int          cnt;
      logic [31:0] e;
      cnt = 0;
      while (!imem_req && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({name, "_req"}, {31'd0, imem_req}, 32'd1);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_queue: got empty expected entry", name);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_addr"}, imem_addr, e);
      end
   endtask

   initial begin
      logic [31:0] jmp_next;
`ifdef FETCH_JUMP_EN
      jmp_next = 32'h0000_0040;
`else
      jmp_next = 32'h0000_0018;
`endif
      //         pc            rdata         ad rd br bn z  sp next
      vt[0]  = mk(32'h0000_0040, 32'h2008_0005, 2, 1, 0, 0, 0, 0, 32'h0000_0044);
      vt[1]  = mk(32'h0000_0044, 32'h1109_002E, 0, 0, 1, 0, 1, 1, 32'h0000_0100);
      vt[2]  = mk(32'h0000_0100, 32'h1109_FFFE, 1, 0, 1, 0, 1, 0, 32'h0000_00FC);
      vt[3]  = mk(32'h0000_00FC, 32'h1000_0000, 0, 2, 1, 0, 1, 0, 32'h0000_0100);
      vt[4]  = mk(32'h0000_0100, 32'h1109_FFFE, 0, 0, 1, 0, 0, 0, 32'h0000_0104);
      vt[5]  = mk(32'h0000_0104, 32'h1509_003E, 1, 0, 0, 1, 0, 0, 32'h0000_0200);
      vt[6]  = mk(32'h0000_0200, 32'h1509_0003, 0, 0, 0, 1, 0, 0, 32'h0000_0210);
      vt[7]  = mk(32'h0000_0210, 32'h1109_FFFB, 0, 0, 1, 0, 1, 0, 32'h0000_0200);
      vt[8]  = mk(32'h0000_0200, 32'h1509_0003, 3, 1, 0, 1, 1, 0, 32'h0000_0204);
      vt[9]  = mk(32'h0000_0204, 32'h1000_FF7D, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFC);
      vt[10] = mk(32'hFFFF_FFFC, 32'h2008_0005, 0, 0, 0, 0, 0, 1, 32'h0000_0000);
      vt[11] = mk(32'h0000_0000, 32'h1000_0004, 0, 0, 1, 1, 0, 0, 32'h0000_0014);
      vt[12] = mk(32'h0000_0014, 32'h0800_0010, 0, 0, 0, 0, 0, 0, jmp_next);

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; retire = 1'b0;
      branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
      tick();
      tick();
      chk("rst_req",   {31'd0, imem_req},    32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'd0);
      chk("rst_pc",    pc,                   c_RESET_PC);
      rst = 1'b0;
      #1;
      chk("rel_req_low", {31'd0, imem_req}, 32'd0);
      exp_q.push_back(c_RESET_PC);

      for (int i = 0; i < c_NVEC; i++) begin
         string nm;
         logic [31:0] held;
         nm = $sformatf("v%0d", i);
         check_fetch(nm);
         if (vt[i].spur) begin
            // retire while fetching must not move the PC
            retire = 1'b1; branch = 1'b1; zero = 1'b1;
            tick();
            retire = 1'b0; branch = 1'b0; zero = 1'b0;
            chk({nm, "_spret_addr"}, imem_addr, vt[i].pc);
            chk({nm, "_spret_req"}, {31'd0, imem_req}, 32'd1);
         end
         repeat (vt[i].ack_dly) tick();
         imem_ack = 1'b1; imem_rdata = vt[i].rdata;
         tick();
         imem_ack = 1'b0; imem_rdata = $urandom;
         held = vt[i].rdata;
         chk({nm, "_valid"},  {31'd0, instr_valid}, 32'd1);
         chk({nm, "_reqlow"}, {31'd0, imem_req},    32'd0);
         chk({nm, "_instr"},  instr, held);
         chk({nm, "_opcode"}, {26'd0, opcode}, {26'd0, held[31:26]});
         chk({nm, "_pc"},     pc, vt[i].pc);
         chk({nm, "_pc4"},    pc_plus4, vt[i].pc + 32'd4);
         if (vt[i].spur) begin
            // ack while issuing must not overwrite IR
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            tick();
            imem_ack = 1'b0;
            chk({nm, "_spack_instr"}, instr, held);
            chk({nm, "_spack_valid"}, {31'd0, instr_valid}, 32'd1);
         end
         repeat (vt[i].ret_dly) tick();
         chk({nm, "_hold_pc"}, pc, vt[i].pc);
         retire = 1'b1; branch = vt[i].br; branch_ne = vt[i].bne; zero = vt[i].z;
         tick();
         retire = 1'b0; branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
         exp_q.push_back(vt[i].next);
         chk({nm, "_ret_req"},   {31'd0, imem_req},    32'd1);
         chk({nm, "_ret_valid"}, {31'd0, instr_valid}, 32'd0);
      end
      check_fetch("final");

      // Reset lands in the same cycle as an ack: the ack is dropped
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005; rst = 1'b1;
      #1;
      chk("mrst_req_now", {31'd0, imem_req}, 32'd0);
      chk("mrst_pc_now",  pc, c_RESET_PC);
      tick();
      imem_ack = 1'b0;
      chk("mrst_instr", instr, 32'd0);
      chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mrst_rel_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("mrst_req_up", {31'd0, imem_req}, 32'd1);
      chk("mrst_addr",   imem_addr, c_RESET_PC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
